// File: rtl/blink_scheduler_if.sv
// Bundle carrying enable/beat/speed strobes into blink_scheduler and its
// exponent, phase and LED outputs back out.
interface blink_scheduler_if #(
    parameter int EXP_W = 3
);
    logic             enable;
    logic             beat;
    logic             shift_left_1;
    logic             shift_right_1;
    logic             shift_left_2;
    logic             shift_right_2;
    logic [EXP_W-1:0] exp_1;
    logic [EXP_W-1:0] exp_2;
    logic [2:0]       phase;
    logic             led;
    logic             phase_done;

    modport master (
        output enable,
        output beat,
        output shift_left_1,
        output shift_right_1,
        output shift_left_2,
        output shift_right_2,
        input  exp_1,
        input  exp_2,
        input  phase,
        input  led,
        input  phase_done
    );

    modport slave (
        input  enable,
        input  beat,
        input  shift_left_1,
        input  shift_right_1,
        input  shift_left_2,
        input  shift_right_2,
        output exp_1,
        output exp_2,
        output phase,
        output led,
        output phase_done
    );
endinterface

// File: rtl/blink_scheduler.sv
// Saturating two-speed, phase-aware LED blink scheduler driven by beat ticks.
// Optional BLINK_SPEED_RESTART_EN: speed change restarts the running phase.
module blink_scheduler #(
    parameter int MAX_EXP     = 7,
    parameter int EXP_W       = 3,
    parameter int DEFAULT_EXP = 2
) (
    input logic              clock,
    input logic              reset,
    blink_scheduler_if.slave bus
);
    localparam int CNT_W = MAX_EXP;

    localparam logic [EXP_W-1:0] EXP_TOP = EXP_W'(MAX_EXP);
    localparam logic [EXP_W-1:0] EXP_RST = EXP_W'(DEFAULT_EXP);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ON1  = 3'd1,
        OFF1 = 3'd2,
        ON2  = 3'd3,
        OFF2 = 3'd4
    } phase_e;

    logic [EXP_W-1:0] exp1_q;
    logic [EXP_W-1:0] exp1_d;
    logic [EXP_W-1:0] exp2_q;
    logic [EXP_W-1:0] exp2_d;
    phase_e           state_q;
    phase_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             done_q;
    logic             done_d;

    logic idle_entry;
    logic running;
    logic tick_dec;
    logic tick_adv;

    // Beats remaining after the current one: 2^e - 1.
    function automatic logic [CNT_W-1:0] span(
        input logic [EXP_W-1:0] e
    );
        logic [CNT_W:0] one_hot;
        one_hot = (CNT_W+1)'(1) << e;
        return CNT_W'(one_hot - (CNT_W+1)'(1));
    endfunction

    function automatic logic [EXP_W-1:0] step_exp(
        input logic [EXP_W-1:0] e,
        input logic             dn,
        input logic             up
    );
        logic [EXP_W-1:0] r;
        r = e;
        unique case (1'b1)
            dn && !up: begin
                if (e != '0)
                    r = e - EXP_W'(1);
            end
            up && !dn: begin
                if (e < EXP_TOP)
                    r = e + EXP_W'(1);
            end
            default: ;
        endcase
        return r;
    endfunction

    function automatic phase_e next_phase(input phase_e p);
        phase_e n;
        case (p)
            ON1:     n = OFF1;
            OFF1:    n = ON2;
            ON2:     n = OFF2;
            default: n = ON1;
        endcase
        return n;
    endfunction

    function automatic logic [EXP_W-1:0] phase_exp(
        input phase_e           p,
        input logic [EXP_W-1:0] e1,
        input logic [EXP_W-1:0] e2
    );
        return (p == ON2 || p == OFF2) ? e2 : e1;
    endfunction

    always_comb begin
        exp1_d = step_exp(exp1_q, bus.shift_left_1, bus.shift_right_1);
        exp2_d = step_exp(exp2_q, bus.shift_left_2, bus.shift_right_2);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            exp1_q  <= EXP_RST;
            exp2_q  <= EXP_RST;
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            exp1_q  <= exp1_d;
            exp2_q  <= exp2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign idle_entry = bus.enable && (state_q == IDLE);
    assign running    = bus.enable && (state_q != IDLE);
    assign tick_dec   = running && bus.beat && (cnt_q != '0);
    assign tick_adv   = running && bus.beat && (cnt_q == '0);

    // Loads use the exponents registered at the load edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (1'b1)
            !bus.enable: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            idle_entry: begin
                state_d = ON1;
                cnt_d   = span(exp1_q);
            end
            tick_dec: begin
                cnt_d = cnt_q - CNT_W'(1);
            end
            tick_adv: begin
                state_d = next_phase(state_q);
                cnt_d   = span(phase_exp(state_d, exp1_q, exp2_q));
                done_d  = 1'b1;
            end
            default: ;
        endcase
`ifdef BLINK_SPEED_RESTART_EN
        if (state_d != IDLE &&
            phase_exp(state_d, exp1_d, exp2_d) !=
            phase_exp(state_d, exp1_q, exp2_q))
            cnt_d = span(phase_exp(state_d, exp1_d, exp2_d));
`endif
    end

    always_comb begin
        bus.exp_1      = exp1_q;
        bus.exp_2      = exp2_q;
        bus.phase      = state_q;
        bus.phase_done = done_q;
        bus.led        = 1'b0;
        unique case (state_q)
            ON1, ON2: bus.led = 1'b1;
            default:  ;
        endcase
    end
endmodule

// File: doc/blink_scheduler.md
Name: blink_scheduler

Overview:
- Owns the two blink-speed settings that the master FSM adjusts through its shift_left/shift_right strobes.
- Sequences the two-rate blink pattern on the LED from a shared beat tick.
- Sits between master_fsm (the speed-adjust strobes) and the LED driver.
- Replaces the free-running shifter pair with a saturating, phase-aware scheduler.

Parameters:
- MAX_EXP, 7: largest speed exponent; a phase lasts 2^exp beats, exp in 0..MAX_EXP.
- EXP_W, 3: width of the exponent registers; must hold MAX_EXP.
- DEFAULT_EXP, 2: exponent loaded into both speed registers on reset.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- enable  in  1  level; high runs the pattern, low parks it in IDLE.
- beat  in  1  single-cycle tick from the beat counter; all durations are counted in beats.
- shift_left_1  in  1  pulse; speed 1 faster (exp_1 decrements).
- shift_right_1  in  1  pulse; speed 1 slower (exp_1 increments).
- shift_left_2  in  1  pulse; speed 2 faster (exp_2 decrements).
- shift_right_2  in  1  pulse; speed 2 slower (exp_2 increments).
- exp_1  out  EXP_W  current speed-1 exponent.
- exp_2  out  EXP_W  current speed-2 exponent.
- phase  out  3  FSM state: 0 IDLE, 1 ON1, 2 OFF1, 3 ON2, 4 OFF2.
- led  out  1  high in ON1 and ON2, low otherwise.
- phase_done  out  1  one-cycle pulse on the edge that leaves any non-IDLE phase.

Behaviour:
- Reset values:
  - exp_1 = exp_2 = DEFAULT_EXP.
  - phase = IDLE, led = 0, phase_done = 0.
  - Internal beat counter cnt = 0.
- Exponent update, evaluated every cycle independent of enable and phase:
  - left only: exp-1, saturating at 0.
  - right only: exp+1, saturating at MAX_EXP.
  - left and right together, or neither: no change.
  - The new value is visible one cycle after the strobe.
- FSM states and transitions:
  - IDLE -> ON1 on the first edge with enable=1. cnt loads (1<<exp_1)-1.
  - A beat in the entry cycle is ignored.
  - ON1 -> OFF1 -> ON2 -> OFF2 -> ON1, looping.
  - In a non-IDLE phase, a beat with cnt != 0 decrements cnt.
  - A beat with cnt == 0 advances the phase and pulses phase_done.
  - On that same edge cnt reloads from the exponent of the new phase: exp_1 for ON1/OFF1, exp_2 for ON2/OFF2.
  - Each phase therefore lasts exactly 2^exp beats.
- Width rules:
  - cnt is MAX_EXP bits wide, so the maximum load is 2^MAX_EXP - 1.
  - The load uses the exponent value registered at the load edge.
  - A speed change mid-phase takes effect at the next phase load.
- Control boundaries:
  - enable=0 in any state: IDLE on the next edge, cnt=0, led=0, no phase_done.
  - enable and beat together while in IDLE: IDLE -> ON1 only; no count.
  - Re-enable always restarts at ON1.
- led and phase are registered outputs, decoded from the state register.
- Reset asserted mid-pattern:
  - Outputs drop to reset values without waiting for a clock edge.
  - Exponents return to DEFAULT_EXP.
  - After release, the first edge with enable=1 enters ON1.

Optional Feature:
- Macro: BLINK_SPEED_RESTART_EN.
- Defined:
  - An exponent change that affects the current phase reloads cnt on the same edge as the exponent update, from the new exponent.
  - The affecting changes are exp_1 in ON1/OFF1 and exp_2 in ON2/OFF2.
  - No phase_done is generated.
  - Saturated or no-op strobes do not restart the count.
- Undefined: changes apply only at the next phase load, as described in Behaviour.

Test Plan:
- Reset, then enable=1 with beat every 4 cycles, defaults (exp=2) -> phase 1,2,3,4,1 each lasting 4 beats (16 cycles); led 1,0,1,0; phase_done pulses once per transition.
- Six shift_left_1 pulses from reset -> exp_1 = 1, 0, 0, 0, 0, 0. Then ten shift_right_2 pulses -> exp_2 saturates at 7; ON2 lasts 128 beats.
- shift_left_1 and shift_right_1 asserted in the same cycle -> exp_1 unchanged at 2.
- In ON1 after 1 beat, pulse shift_right_1 (exp_1 -> 3):
  - macro off: ON1 ends after 4 beats total; the next ON1 lasts 8 beats.
  - macro on: ON1 lasts 1 + 8 beats.
- Drop enable mid-OFF1 -> phase=0, led=0 next cycle, no phase_done. Re-raise enable -> ON1 with a full 2^exp_1 count.
- Assert reset asynchronously mid-ON2 with exp_2=5 -> phase=0, led=0, exp_1=exp_2=2 before the next clock edge.
